// File: rtl/wr_ptr_burst.sv
`default_nettype none
// ============================================================================
// Module      : wr_ptr_burst
// Description : Write-side pointer controller for a circular-buffer FIFO.
//               Each accepted write advances the pointer by 1..MAX_INCR words.
//               Registered level, free space, full, almost-full and sticky
//               overflow status are derived from the next pointer and the
//               read pointer supplied by the read-side controller.
//               Optional macro WR_PTR_GRAY_EN adds a registered Gray-coded
//               copy of the write pointer (o_wptr_gray).
// Revision    : 1.0 - initial release
// ============================================================================
module wr_ptr_burst #(
   parameter int ALEN     = 8,
   parameter int MAX_INCR = 4,
   parameter int CW       = $clog2(MAX_INCR + 1)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_wen,
   input  logic [CW-1:0]   i_wcount,
   input  logic [ALEN:0]   i_rptr,
   input  logic [ALEN:0]   i_afull_thresh,
   input  logic            i_ovf_clr,
   output logic            o_ram_wen,
   output logic [ALEN-1:0] o_waddr,
   output logic [ALEN:0]   o_wptr,
   output logic [ALEN:0]   o_wlevel,
   output logic [ALEN:0]   o_wfree,
   output logic            o_wfull,
   output logic            o_wafull,
`ifdef WR_PTR_GRAY_EN
   output logic [ALEN:0]   o_wptr_gray,
`endif
   output logic            o_wovf
);

   // Parameter legality: burst size must lie in 1..2^ALEN, CW is derived.
   generate
      if ((MAX_INCR < 1) || (MAX_INCR > (1 << ALEN))) begin : g_bad_max_incr
         $error("wr_ptr_burst: MAX_INCR must be in 1..2^ALEN");
      end
      if (CW != $clog2(MAX_INCR + 1)) begin : g_bad_cw
         $error("wr_ptr_burst: CW is derived from MAX_INCR and must not be overridden");
      end
   endgenerate

   // Full-buffer word count, 2^ALEN, representable in the ALEN+1 bit pointer width.
   localparam logic [ALEN:0] c_DEPTH = {1'b1, {ALEN{1'b0}}};

   logic [ALEN:0] r_wptr;
   logic [ALEN:0] r_wlevel;
   logic [ALEN:0] r_wfree;
   logic          r_wfull;
   logic          r_wafull;
   logic          r_wovf;

   logic [ALEN:0] w_cnt_ext;
   logic          w_cnt_nz;
   logic          w_fits;
   logic          w_accept;
   logic          w_reject;
   logic [ALEN:0] w_wptr_d;
   logic [ALEN:0] w_lvl;

   // Acceptance against the registered free count, next pointer and next level.
   // Using registered free space is safe: the read pointer only moves forward,
   // so the true free space can only be larger than what r_wfree reports.
   always_comb begin
      w_cnt_ext = (ALEN+1)'(i_wcount);
      w_cnt_nz  = (i_wcount != '0);
      w_fits    = (w_cnt_ext <= r_wfree);
      w_accept  = i_wen & w_cnt_nz & w_fits;
      w_reject  = i_wen & w_cnt_nz & ~w_fits;
      w_wptr_d  = w_accept ? (r_wptr + w_cnt_ext) : r_wptr;
      w_lvl     = w_wptr_d - i_rptr;
   end

   // Pointer and status registers; a write presented during reset is dropped silently.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr   <= '0;
         r_wlevel <= '0;
         r_wfree  <= c_DEPTH;
         r_wfull  <= 1'b0;
         r_wafull <= 1'b0;
         r_wovf   <= 1'b0;
      end else begin
         r_wptr   <= w_wptr_d;
         r_wlevel <= w_lvl;
         r_wfree  <= c_DEPTH - w_lvl;
         r_wfull  <= (w_lvl == c_DEPTH);
         r_wafull <= (w_lvl >= i_afull_thresh);
         if (w_reject) begin
            r_wovf <= 1'b1;          // a fresh overflow beats a same-cycle clear
         end else if (i_ovf_clr) begin
            r_wovf <= 1'b0;
         end
      end
   end

`ifdef WR_PTR_GRAY_EN
   logic [ALEN:0] r_wptr_gray;
   logic [ALEN:0] w_gray_d;

   // Gray encoding of the next binary pointer.
   always_comb begin
      w_gray_d = w_wptr_d ^ (w_wptr_d >> 1);
   end

   // Gray pointer register, updated alongside the binary pointer.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr_gray <= '0;
      end else begin
         r_wptr_gray <= w_gray_d;
      end
   end

`ifndef SYNTHESIS
   // Multi-bit Gray steps are only expected from accepted bursts longer than one word.
   always_ff @(posedge clk) begin
      if (rstn) begin
         assert (($countones(w_gray_d ^ r_wptr_gray) <= 1) ||
                 (w_accept && (w_cnt_ext > (ALEN+1)'(1))))
            else $error("wr_ptr_burst: multi-bit Gray change without multi-word burst");
      end
   end
`endif

   assign o_wptr_gray = r_wptr_gray;
`endif

   assign o_ram_wen = w_accept;
   assign o_waddr   = r_wptr[ALEN-1:0];
   assign o_wptr    = r_wptr;
   assign o_wlevel  = r_wlevel;
   assign o_wfree   = r_wfree;
   assign o_wfull   = r_wfull;
   assign o_wafull  = r_wafull;
   assign o_wovf    = r_wovf;

endmodule
`default_nettype wire

// File: tb/tb_wr_ptr_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_ptr_burst
// Description : Self-checking bench for wr_ptr_burst (ALEN=3, MAX_INCR=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_ptr_burst;

   localparam int ALEN     = 3;
   localparam int MAX_INCR = 4;
   localparam int CW       = 3;
   localparam int NVEC     = 21;

   logic            clk;
   logic            rstn;
   logic            i_wen;
   logic [CW-1:0]   i_wcount;
   logic [ALEN:0]   i_rptr;
   logic [ALEN:0]   i_afull_thresh;
   logic            i_ovf_clr;
   logic            o_ram_wen;
   logic [ALEN-1:0] o_waddr;
   logic [ALEN:0]   o_wptr;
   logic [ALEN:0]   o_wlevel;
   logic [ALEN:0]   o_wfree;
   logic            o_wfull;
   logic            o_wafull;
   logic            o_wovf;
`ifdef WR_PTR_GRAY_EN
   logic [ALEN:0]   o_wptr_gray;
`endif

   int checks = 0;
   int errors = 0;

   wr_ptr_burst #(.ALEN(ALEN), .MAX_INCR(MAX_INCR)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .i_wen          (i_wen),
      .i_wcount       (i_wcount),
      .i_rptr         (i_rptr),
      .i_afull_thresh (i_afull_thresh),
      .i_ovf_clr      (i_ovf_clr),
      .o_ram_wen      (o_ram_wen),
      .o_waddr        (o_waddr),
      .o_wptr         (o_wptr),
      .o_wlevel       (o_wlevel),
      .o_wfree        (o_wfree),
      .o_wfull        (o_wfull),
      .o_wafull       (o_wafull),
`ifdef WR_PTR_GRAY_EN
      .o_wptr_gray    (o_wptr_gray),
`endif
      .o_wovf         (o_wovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The read pointer must never run ahead of the write pointer.
   logic [ALEN:0] r_occ;
   always @(posedge clk) begin
      if (rstn === 1'b1) begin
         r_occ = o_wptr - i_rptr;
         assert (r_occ <= 4'd8) else $error("illegal read pointer: occupancy %0d", r_occ);
      end
   end

   typedef struct {
      logic          rstn;
      logic          wen;
      logic [CW-1:0] cnt;
      logic [ALEN:0] rptr;
      logic [ALEN:0] th;
      logic          clr;
      logic          ren;
      logic [ALEN:0] wptr;
      logic [ALEN:0] lvl;
      logic [ALEN:0] free;
      logic          full;
      logic          af;
      logic          ovf;
   } vec_t;

   vec_t vecs[NVEC];

   function automatic vec_t mk(int rs, int we, int ct, int rp, int th, int cl,
                               int re, int wp, int lv, int fr, int fu, int af, int ov);
      vec_t m;
      m.rstn = 1'(rs);  m.wen  = 1'(we);   m.cnt  = CW'(ct);
      m.rptr = 4'(rp);  m.th   = 4'(th);   m.clr  = 1'(cl);
      m.ren  = 1'(re);  m.wptr = 4'(wp);   m.lvl  = 4'(lv);
      m.free = 4'(fr);  m.full = 1'(fu);   m.af   = 1'(af);
      m.ovf  = 1'(ov);
      return m;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   initial begin
      int accepted;
      int af_at;
      logic [ALEN:0] exp_wptr;

      rstn = 1'b0; i_wen = 1'b0; i_wcount = '0; i_rptr = '0;
      i_afull_thresh = 4'd6; i_ovf_clr = 1'b0;

      //               rs we ct rp th cl | ren wptr lvl free full af ovf
      vecs[0]  = mk(0, 0, 0,  0, 6, 0,   0,  0, 0, 8, 0, 0, 0); // reset
      vecs[1]  = mk(1, 0, 0,  0, 6, 0,   0,  0, 0, 8, 0, 0, 0); // idle
      vecs[2]  = mk(1, 1, 4,  0, 6, 0,   1,  4, 4, 4, 0, 0, 0); // write 4
      vecs[3]  = mk(1, 1, 4,  0, 6, 0,   1,  8, 8, 0, 1, 1, 0); // exact fill
      vecs[4]  = mk(1, 1, 1,  0, 6, 0,   0,  8, 8, 0, 1, 1, 1); // write at full
      vecs[5]  = mk(1, 0, 0,  0, 6, 1,   0,  8, 8, 0, 1, 1, 0); // clear ovf
      vecs[6]  = mk(1, 0, 0,  2, 6, 0,   0,  8, 6, 2, 0, 1, 0); // reader frees 2
      vecs[7]  = mk(1, 1, 3,  2, 6, 1,   0,  8, 6, 2, 0, 1, 1); // partial reject + clr
      vecs[8]  = mk(1, 1, 2,  2, 6, 0,   1, 10, 8, 0, 1, 1, 1); // write 2 to full
      vecs[9]  = mk(1, 0, 0,  2, 6, 1,   0, 10, 8, 0, 1, 1, 0); // clear
      vecs[10] = mk(1, 1, 0,  2, 6, 0,   0, 10, 8, 0, 1, 1, 0); // zero count no-op
      vecs[11] = mk(1, 0, 0, 10, 6, 0,   0, 10, 0, 8, 0, 0, 0); // drain
      vecs[12] = mk(1, 1, 4, 10, 6, 0,   1, 14, 4, 4, 0, 0, 0);
      vecs[13] = mk(1, 1, 1, 13, 6, 0,   1, 15, 2, 6, 0, 0, 0); // wptr 15, rptr 13
      vecs[14] = mk(1, 1, 2, 13, 6, 0,   1,  1, 4, 4, 0, 0, 0); // wrap
      vecs[15] = mk(1, 1, 1, 13, 6, 0,   1,  2, 5, 3, 0, 0, 0); // level 5
      vecs[16] = mk(1, 1, 1, 13, 6, 0,   1,  3, 6, 2, 0, 1, 0); // almost full
      vecs[17] = mk(1, 1, 3, 14, 6, 0,   0,  3, 5, 3, 0, 0, 1); // rptr+1, reject
      vecs[18] = mk(0, 1, 3,  0, 6, 0,   1,  0, 0, 8, 0, 0, 0); // reset mid-burst
      vecs[19] = mk(1, 0, 0,  0, 0, 0,   0,  0, 0, 8, 0, 1, 0); // threshold 0
      vecs[20] = mk(1, 1, 4,  0, 0, 0,   1,  4, 4, 4, 0, 1, 0);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rstn = vecs[i].rstn; i_wen = vecs[i].wen; i_wcount = vecs[i].cnt;
         i_rptr = vecs[i].rptr; i_afull_thresh = vecs[i].th; i_ovf_clr = vecs[i].clr;
         #1;
         chk("ram_wen", i, 32'(o_ram_wen), 32'(vecs[i].ren));
         @(posedge clk);
         #1;
         exp_wptr = vecs[i].wptr;
         chk("wptr",   i, 32'(o_wptr),   32'(exp_wptr));
         chk("waddr",  i, 32'(o_waddr),  32'(exp_wptr[ALEN-1:0]));
         chk("wlevel", i, 32'(o_wlevel), 32'(vecs[i].lvl));
         chk("wfree",  i, 32'(o_wfree),  32'(vecs[i].free));
         chk("wfull",  i, 32'(o_wfull),  32'(vecs[i].full));
         chk("wafull", i, 32'(o_wafull), 32'(vecs[i].af));
         chk("wovf",   i, 32'(o_wovf),   32'(vecs[i].ovf));
      end

      // Fill one word at a time from empty; full must appear after exactly 8 writes
      // and almost-full (threshold 6) must first show after the sixth.
      @(negedge clk);
      rstn = 1'b0; i_wen = 1'b0; i_wcount = '0; i_rptr = '0;
      i_afull_thresh = 4'd6; i_ovf_clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      accepted = 0;
      af_at = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (o_wfull) break;
         i_wen = 1'b1; i_wcount = 3'd1;
         #1;
         if (o_ram_wen) accepted++;
         @(posedge clk);
         #1;
         if (o_wafull && af_at < 0) af_at = accepted;
      end
      i_wen = 1'b0; i_wcount = '0;
      chk("fill_reached_full", 100, 32'(o_wfull), 32'd1);
      chk("fill_accepted",     100, 32'(accepted), 32'd8);
      chk("fill_afull_point",  100, 32'(af_at), 32'd6);
      chk("fill_wptr",         100, 32'(o_wptr), 32'd8);

      // A maximum burst at full is rejected and flagged; pointer holds.
      @(negedge clk);
      i_wen = 1'b1; i_wcount = 3'd4;
      #1;
      chk("full_burst_ram_wen", 101, 32'(o_ram_wen), 32'd0);
      @(posedge clk);
      #1;
      chk("full_burst_ovf",  101, 32'(o_wovf), 32'd1);
      chk("full_burst_wptr", 101, 32'(o_wptr), 32'd8);
      @(negedge clk);
      i_wen = 1'b0; i_wcount = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
